time_keeper: RTL and testbench

Time-of-day core for the digital clock: counts seconds, minutes and hours in packed BCD (00:00:00–23:59:59) from a one-cycle 1 Hz enable, and supports manual hour/minute adjustment at the 10 Hz rate. Its `Hr`/`Min` outputs are the live time that the alarm block compares against its set time. It also drives the display time. Optionally it generates an hourly chime.

---
 rtl/time_keeper_if.sv | 36 +++
 rtl/time_keeper.sv | 126 ++++++++++++
 tb/tb_time_keeper.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/time_keeper_if.sv
// Control/time bus between the time-of-day core and its users (display, alarm).
// The chime signal exists only when HOURLY_CHIME_EN is defined.
interface time_keeper_if;
  localparam int unsigned BCD_W = 8;

  logic             tick_1hz;
  logic             tick_10hz;
  logic             Mode;
  logic             adjHr;
  logic             adjMin;
  logic [BCD_W-1:0] Hr;
  logic [BCD_W-1:0] Min;
  logic [BCD_W-1:0] Sec;
  logic             min_strobe;
`ifdef HOURLY_CHIME_EN
  logic             chime;
`endif

  // Driver side: produces ticks and adjust requests, consumes the time.
  modport master (
    output tick_1hz, tick_10hz, Mode, adjHr, adjMin,
`ifdef HOURLY_CHIME_EN
    input  chime,
`endif
    input  Hr, Min, Sec, min_strobe
  );

  // Core side.
  modport slave (
    input  tick_1hz, tick_10hz, Mode, adjHr, adjMin,
`ifdef HOURLY_CHIME_EN
    output chime,
`endif
    output Hr, Min, Sec, min_strobe
  );
endinterface

// File: rtl/time_keeper.sv
// Time-of-day core: packed-BCD hh:mm:ss counter driven by a 1 Hz enable, with 10 Hz
// manual hour/minute adjust. Define HOURLY_CHIME_EN to add the registered hourly chime.
module time_keeper (
  input  logic         CP,
  input  logic         CR,
  time_keeper_if.slave tk
);
  localparam int unsigned DIG_W = 4;
  localparam int unsigned BCD_W = 8;

  logic [BCD_W-1:0] hr_q, min_q, sec_q;
  logic             strobe_q;
  logic [BCD_W-1:0] hr_d, min_d, sec_d;
  logic             strobe_d;
  logic             adj_m, adj_h, sc, mc;

  // Modulo-60 BCD increment used by both seconds and minutes.
  function automatic logic [BCD_W-1:0] inc_60(input logic [BCD_W-1:0] v);
    logic [DIG_W-1:0] t, u;
    t = v[7:4];
    u = v[3:0];
    if (u == DIG_W'(9)) begin
      u = '0;
      t = (t == DIG_W'(5)) ? '0 : t + DIG_W'(1);
    end else begin
      u = u + DIG_W'(1);
    end
    return {t, u};
  endfunction

  // Modulo-24 BCD increment; units only wrap at 9 while tens is below 2.
  function automatic logic [BCD_W-1:0] inc_24(input logic [BCD_W-1:0] v);
    logic [DIG_W-1:0] t, u;
    t = v[7:4];
    u = v[3:0];
    if (v == BCD_W'(8'h23)) begin
      t = '0;
      u = '0;
    end else if (u == DIG_W'(9)) begin
      u = '0;
      t = t + DIG_W'(1);
    end else begin
      u = u + DIG_W'(1);
    end
    return {t, u};
  endfunction

  // Adjust requests are active-low and only honoured in time mode.
  assign adj_m = ~tk.adjMin & ~tk.Mode & tk.tick_10hz;
  assign adj_h = ~tk.adjHr  & ~tk.Mode & tk.tick_10hz;

  // Whole sec->min->hr carry chain resolves in one edge.
  always_comb begin
    sec_d    = sec_q;
    min_d    = min_q;
    hr_d     = hr_q;
    sc       = 1'b0;
    mc       = 1'b0;

    if (tk.tick_1hz) begin
      sec_d = inc_60(sec_q);
      sc    = (sec_q == BCD_W'(8'h59));
    end

    // Adjustment wins over the seconds carry, which is then dropped.
    if (adj_m) begin
      min_d = inc_60(min_q);
    end else if (sc) begin
      min_d = inc_60(min_q);
      mc    = (min_q == BCD_W'(8'h59));
    end

    if (adj_h || mc) begin
      hr_d = inc_24(hr_q);
    end

    // Every minute update is a real change, so the strobe is just "minutes moved".
    strobe_d = adj_m | sc;
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      hr_q     <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      hr_q     <= hr_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      strobe_q <= strobe_d;
    end
  end

  assign tk.Hr         = hr_q;
  assign tk.Min        = min_q;
  assign tk.Sec        = sec_q;
  assign tk.min_strobe = strobe_q;

`ifdef HOURLY_CHIME_EN
  logic chime_q;
  logic chime_d;

  // Evaluated on the next-state time so the chime lines up with the displayed second.
  always_comb begin
    chime_d = 1'b0;
    if (min_d == BCD_W'(8'h59)) begin
      case (sec_d)
        BCD_W'(8'h51), BCD_W'(8'h53), BCD_W'(8'h55),
        BCD_W'(8'h57), BCD_W'(8'h59): chime_d = 1'b1;
        default:                      chime_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      chime_q <= 1'b0;
    end else begin
      chime_q <= chime_d;
    end
  end

  assign tk.chime = chime_q;
`endif
endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper: an integer-arithmetic time model predicts every cycle,
// a monitor compares the DUT outputs against the queued predictions.
module tb_time_keeper;
  logic CP = 1'b0;
  logic CR;

  time_keeper_if tkif ();

  time_keeper dut (
    .CP (CP),
    .CR (CR),
    .tk (tkif)
  );

  always #5 CP = ~CP;

  typedef struct packed {
    logic [7:0] hr;
    logic [7:0] mn;
    logic [7:0] sc;
    logic       strobe;
    logic       chime;
  } exp_t;

  exp_t sbq[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   strobe_cnt = 0;

  // Reference model: plain integers for hours, minutes and seconds.
  int m_h = 0, m_m = 0, m_s = 0;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic check(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Apply one cycle of inputs and push the predicted post-edge outputs.
  task automatic drive(input bit cr, input bit t1, input bit t10, input bit mode,
                       input bit ahr_n, input bit amin_n);
    exp_t e;
    bit am, ah, sc, mc;
    @(negedge CP);
    CR             = cr;
    tkif.tick_1hz  = t1;
    tkif.tick_10hz = t10;
    tkif.Mode      = mode;
    tkif.adjHr     = ahr_n;
    tkif.adjMin    = amin_n;
    am = !amin_n && !mode && t10;
    ah = !ahr_n && !mode && t10;
    sc = 1'b0;
    mc = 1'b0;
    if (cr) begin
      m_h = 0; m_m = 0; m_s = 0;
      am  = 1'b0;
    end else begin
      if (t1) begin
        sc  = (m_s == 59);
        m_s = (m_s + 1) % 60;
      end
      if (am) m_m = (m_m + 1) % 60;
      else if (sc) begin
        mc  = (m_m == 59);
        m_m = (m_m + 1) % 60;
      end
      if (ah || mc) m_h = (m_h + 1) % 24;
    end
    e.hr     = to_bcd(m_h);
    e.mn     = to_bcd(m_m);
    e.sc     = to_bcd(m_s);
    e.strobe = !cr && (am || sc);
    e.chime  = !cr && m_m == 59 && m_s >= 51 && (m_s % 2) == 1;
    sbq.push_back(e);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
  endtask

  task automatic adj_hr(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      idle();
    end
  endtask

  task automatic adj_min(input int n, input bit mode);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b1, mode, 1'b1, 1'b0);
      idle();
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
  endtask

  // Monitor: every edge is an output event; compare against the oldest prediction.
  always @(posedge CP) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("sb_hr",     32'(tkif.Hr),  32'(e.hr));
      check("sb_min",    32'(tkif.Min), 32'(e.mn));
      check("sb_sec",    32'(tkif.Sec), 32'(e.sc));
      check("sb_strobe", 32'(tkif.min_strobe), 32'(e.strobe));
`ifdef HOURLY_CHIME_EN
      check("sb_chime",  32'(tkif.chime), 32'(e.chime));
`endif
      if (tkif.min_strobe) strobe_cnt++;
    end
  end

  initial begin
    int chime_hits;
    int waited;
    CR = 1'b1;
    tkif.tick_1hz  = 1'b0;
    tkif.tick_10hz = 1'b0;
    tkif.Mode      = 1'b0;
    tkif.adjHr     = 1'b1;
    tkif.adjMin    = 1'b1;

    // Reset state
    do_reset();
    check("rst_hr",  32'(tkif.Hr), 32'h00);
    check("rst_min", 32'(tkif.Min), 32'h00);
    check("rst_sec", 32'(tkif.Sec), 32'h00);
    check("rst_strobe", 32'(tkif.min_strobe), 0);

    // 3661 seconds -> 01:01:01 with 61 minute changes
    strobe_cnt = 0;
    ticks(3661);
    check("t3661_hr",  32'(tkif.Hr),  32'h01);
    check("t3661_min", 32'(tkif.Min), 32'h01);
    check("t3661_sec", 32'(tkif.Sec), 32'h01);
    check("t3661_strobes", strobe_cnt, 61);

    // Midnight rollover from 23:59:58
    do_reset();
    adj_hr(23);
    adj_min(59, 1'b0);
    ticks(58);
    tick();
    check("roll1_sec", 32'(tkif.Sec), 32'h59);
    tick();
    check("roll2_hr",  32'(tkif.Hr),  32'h00);
    check("roll2_min", 32'(tkif.Min), 32'h00);
    check("roll2_sec", 32'(tkif.Sec), 32'h00);
    check("roll2_strobe", 32'(tkif.min_strobe), 1);

    // Minute adjust wraps without carrying into hours; Mode=1 ignores it
    do_reset();
    adj_hr(10);
    adj_min(65, 1'b0);
    check("adj_min", 32'(tkif.Min), 32'h05);
    check("adj_hr",  32'(tkif.Hr),  32'h10);
    adj_min(65, 1'b1);
    check("mode1_min", 32'(tkif.Min), 32'h05);

    // Tick + adjM + adjH together at 09:59:59
    do_reset();
    adj_hr(9);
    adj_min(59, 1'b0);
    ticks(59);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    check("sim_hr",  32'(tkif.Hr),  32'h10);
    check("sim_min", 32'(tkif.Min), 32'h00);
    check("sim_sec", 32'(tkif.Sec), 32'h00);

    // Clear coincident with a tick at 12:34:56
    do_reset();
    adj_hr(12);
    adj_min(34, 1'b0);
    ticks(56);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();
    check("clr_hr",  32'(tkif.Hr),  32'h00);
    check("clr_min", 32'(tkif.Min), 32'h00);
    check("clr_sec", 32'(tkif.Sec), 32'h00);
    check("clr_strobe", 32'(tkif.min_strobe), 0);

    // Hourly chime window 05:59:49 -> 06:00:01
    do_reset();
    adj_hr(5);
    adj_min(59, 1'b0);
    ticks(49);
    chime_hits = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
`ifdef HOURLY_CHIME_EN
      if (tkif.chime) chime_hits++;
`endif
    end
    check("chime_end_hr",  32'(tkif.Hr),  32'h06);
    check("chime_end_sec", 32'(tkif.Sec), 32'h01);
`ifdef HOURLY_CHIME_EN
    check("chime_hits", chime_hits, 5);
`endif

    // Random traffic, including back-to-back and overlapping requests
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 250) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
            ($urandom % 4) == 0, ($urandom % 3) != 0, ($urandom % 3) != 0);
    end
    idle();

    waited = 0;
    while (sbq.size() > 0 && waited < 10) begin
      @(posedge CP);
      waited++;
    end
    #2;
    if (sbq.size() > 0) begin
      mismatched++;
      $display("FAIL drain: %0d predictions left, expected 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
